// File: rtl/mem_access_stage.sv
// mem_access_stage
//   Memory-stage access unit. Converts load/store requests from EX/M into a
//   req/ack data-memory transaction (byte enables, replicated store data),
//   flags misaligned accesses, stalls the pipeline while a transaction is
//   outstanding, and owns the M/W pipeline register feeding write-back.
// Ports
//   clk, reset_n                 clock, asynchronous active-low reset
//   valid_m, flush_m             M-stage instruction valid / kill
//   RegWriteM .. PC_4M           M-stage control and data
//   dm_req/we/addr/be/wdata      data-memory request (held until dm_ack)
//   dm_ack, dm_rdata             data-memory completion and read data
//   stall_m                      freeze F/D/E/M
//   exc_adel, exc_ades           misaligned load / store (IDLE only)
//   bus_err                      one-cycle pulse on ack timeout
//   RegWriteW .. PC_4W           M/W register contents
//
// state | meaning
// IDLE  | no transaction outstanding, M/W register advances each cycle
// BUSY  | request on the bus, pipeline stalled until dm_ack or timeout
module mem_access_stage #(
  parameter int unsigned ACK_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        valid_m,
  input  logic        flush_m,
  input  logic        RegWriteM,
  input  logic [1:0]  MemtoRegM,
  input  logic [2:0]  LoadopM,
  input  logic [1:0]  StoreopM,
  input  logic [31:0] ALUoutM,
  input  logic [31:0] WriteDataM,
  input  logic [4:0]  AwriteM,
  input  logic [31:0] PC_4M,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        stall_m,
  output logic        exc_adel,
  output logic        exc_ades,
  output logic        bus_err,
  output logic        RegWriteW,
  output logic [1:0]  MemtoRegW,
  output logic [2:0]  LoadopW,
  output logic [31:0] RDW,
  output logic [31:0] ALUoutW,
  output logic [4:0]  AwriteW,
  output logic [31:0] PC_4W
);

  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic [1:0] {W_HOLD, W_BUBBLE, W_LOAD, W_LOAD_RD} w_op_t;

  // Counter only has to reach ACK_TIMEOUT-1; the timeout fires on that cycle.
  localparam int unsigned CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = (ACK_TIMEOUT > 0) ? CW'(ACK_TIMEOUT - 1) : '0;

  state_t        state_q, state_d;
  w_op_t         w_op;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          kill_q, kill_d;
  logic          bus_err_q, bus_err_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   wdata_q, wdata_d;

  logic        is_store, is_load, mem_op, misaligned, timeout_hit;
  logic [3:0]  be_st;
  logic [31:0] wdata_st;

  // A store opcode takes precedence if both load and store are signalled.
  assign is_store    = (StoreopM != 2'd0);
  assign is_load     = (MemtoRegM == 2'd1) && !is_store;
  assign mem_op      = valid_m && !flush_m && (is_load || is_store);
  assign timeout_hit = (ACK_TIMEOUT > 0) && (cnt_q == TO_LAST);

  always_comb begin
    misaligned = 1'b0;
    be_st      = 4'hF;
    wdata_st   = WriteDataM;
    if (is_store) begin
      case (StoreopM)
        2'd1: misaligned = (ALUoutM[1:0] != 2'b00);
        2'd2: begin
          misaligned = ALUoutM[0];
          be_st      = ALUoutM[1] ? 4'b1100 : 4'b0011;
          wdata_st   = {2{WriteDataM[15:0]}};
        end
        2'd3: begin
          be_st    = 4'b0001 << ALUoutM[1:0];
          wdata_st = {4{WriteDataM[7:0]}};
        end
        default: misaligned = 1'b0;
      endcase
    end else begin
      case (LoadopM)
        3'd0:    misaligned = (ALUoutM[1:0] != 2'b00);
        3'd3,
        3'd4:    misaligned = ALUoutM[0];
        default: misaligned = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    kill_d    = kill_q;
    bus_err_d = 1'b0;
    we_d      = we_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    w_op      = W_HOLD;
    stall_m   = 1'b0;
    exc_adel  = 1'b0;
    exc_ades  = 1'b0;
    case (state_q)
      IDLE: begin
        kill_d = 1'b0;
        cnt_d  = '0;
        if (mem_op && misaligned) begin
          exc_adel = is_load;
          exc_ades = is_store;
          w_op     = W_BUBBLE;
        end else if (mem_op) begin
          stall_m = 1'b1;
          we_d    = is_store;
          addr_d  = {ALUoutM[31:2], 2'b00};
          be_d    = is_store ? be_st : 4'hF;
          wdata_d = is_store ? wdata_st : 32'h0;
          w_op    = W_BUBBLE;
          state_d = BUSY;
        end else if (flush_m) begin
          w_op = W_BUBBLE;
        end else begin
          w_op = W_LOAD;
        end
      end
      BUSY: begin
        if (dm_ack) begin
          // A flush seen at any point during the transaction squashes the result.
          w_op    = (kill_q || flush_m) ? W_BUBBLE : W_LOAD_RD;
          state_d = IDLE;
        end else if (timeout_hit) begin
          bus_err_d = 1'b1;
          w_op      = W_BUBBLE;
          state_d   = IDLE;
        end else begin
          stall_m = 1'b1;
          if (flush_m) kill_d = 1'b1;
          if (ACK_TIMEOUT > 0) cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      kill_q    <= 1'b0;
      bus_err_q <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      kill_q    <= kill_d;
      bus_err_q <= bus_err_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      RegWriteW <= 1'b0;
      MemtoRegW <= '0;
      LoadopW   <= '0;
      RDW       <= '0;
      ALUoutW   <= '0;
      AwriteW   <= '0;
      PC_4W     <= '0;
    end else begin
      case (w_op)
        W_BUBBLE: begin
          RegWriteW <= 1'b0;
          MemtoRegW <= '0;
          LoadopW   <= '0;
          RDW       <= '0;
          ALUoutW   <= '0;
          AwriteW   <= '0;
          PC_4W     <= '0;
        end
        W_LOAD, W_LOAD_RD: begin
          RegWriteW <= RegWriteM && (valid_m || (w_op == W_LOAD_RD));
          MemtoRegW <= MemtoRegM;
          LoadopW   <= LoadopM;
          RDW       <= (w_op == W_LOAD_RD) ? dm_rdata : 32'h0;
          ALUoutW   <= ALUoutM;
          AwriteW   <= AwriteM;
          PC_4W     <= PC_4M;
        end
        default: ;
      endcase
    end
  end

  assign dm_req   = (state_q == BUSY);
  assign dm_we    = we_q;
  assign dm_addr  = addr_q;
  assign dm_be    = be_q;
  assign dm_wdata = wdata_q;
  assign bus_err  = bus_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        valid_m = 1'b0, flush_m = 1'b0, RegWriteM = 1'b0;
  logic [1:0]  MemtoRegM = '0;
  logic [2:0]  LoadopM = '0;
  logic [1:0]  StoreopM = '0;
  logic [31:0] ALUoutM = '0, WriteDataM = '0, PC_4M = '0;
  logic [4:0]  AwriteM = '0;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata;
  logic [3:0]  dm_be;
  logic        dm_ack = 1'b0;
  logic [31:0] dm_rdata = '0;
  logic        stall_m, exc_adel, exc_ades, bus_err;
  logic        RegWriteW;
  logic [1:0]  MemtoRegW;
  logic [2:0]  LoadopW;
  logic [31:0] RDW, ALUoutW, PC_4W;
  logic [4:0]  AwriteW;

  int passes = 0;
  int fails  = 0;
  int total  = 0;

  mem_access_stage #(.ACK_TIMEOUT(4)) dut (
    .clk(clk), .reset_n(reset_n), .valid_m(valid_m), .flush_m(flush_m),
    .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .LoadopM(LoadopM), .StoreopM(StoreopM),
    .ALUoutM(ALUoutM), .WriteDataM(WriteDataM), .AwriteM(AwriteM), .PC_4M(PC_4M),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata), .stall_m(stall_m), .exc_adel(exc_adel),
    .exc_ades(exc_ades), .bus_err(bus_err), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW),
    .LoadopW(LoadopW), .RDW(RDW), .ALUoutW(ALUoutW), .AwriteW(AwriteW), .PC_4W(PC_4W)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid_m = 0; flush_m = 0; RegWriteM = 0; MemtoRegM = 0;
    LoadopM = 0; StoreopM = 0; dm_ack = 0;
  endtask

  // Reference model: access size in bytes from the opcode.
  function automatic int unsigned acc_size(input bit st, input logic [2:0] lop, input logic [1:0] sop);
    if (st) return (sop == 1) ? 4 : (sop == 2) ? 2 : 1;
    return (lop == 0) ? 4 : (lop == 3 || lop == 4) ? 2 : 1;
  endfunction

  function automatic logic [3:0] exp_be(input bit st, input logic [1:0] sop, input logic [31:0] a);
    if (!st || sop == 1) return 4'hF;
    if (sop == 2) return ((a / 2) % 2 == 1) ? 4'hC : 4'h3;
    return 4'(1 << (a % 4));
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [1:0] sop, input logic [31:0] wd);
    if (sop == 1) return wd;
    if (sop == 2) return (wd % 65536) * 32'h0001_0001;
    return (wd % 256) * 32'h0101_0101;
  endfunction

  task automatic mem_txn(input bit st, input logic [2:0] lop, input logic [1:0] sop,
                         input logic [31:0] addr, input logic [31:0] wd, input int delay,
                         input int flush_at, input logic [31:0] rdata, input logic [4:0] rd,
                         input bit rw);
    int stall_cnt;
    bit killed;
    logic [31:0] pc;
    pc = $urandom;
    valid_m = 1; flush_m = 0; RegWriteM = rw; MemtoRegM = st ? 2'd0 : 2'd1;
    LoadopM = lop; StoreopM = st ? sop : 2'd0; ALUoutM = addr; WriteDataM = wd;
    AwriteM = rd; PC_4M = pc; dm_ack = 0;
    #1;
    if (addr % acc_size(st, lop, sop) != 0) begin
      check("exc_adel", exc_adel, !st);
      check("exc_ades", exc_ades, st);
      check("mis_stall", stall_m, 0);
      check("mis_req", dm_req, 0);
      step();
      idle_inputs();
      check("mis_bubble", RegWriteW, 0);
      check("mis_req_after", dm_req, 0);
      return;
    end
    check("launch_stall", stall_m, 1);
    check("launch_exc", {exc_adel, exc_ades}, 0);
    stall_cnt = 1;
    killed = 0;
    step();
    for (int i = 0; i < delay; i++) begin
      flush_m = 0;
      check("busy_req", dm_req, 1);
      check("busy_we", dm_we, st);
      check("busy_addr", dm_addr, addr & 32'hFFFF_FFFC);
      check("busy_be", dm_be, exp_be(st, sop, addr));
      if (st) check("busy_wdata", dm_wdata, exp_wdata(sop, wd));
      stall_cnt += stall_m;
      if (i == flush_at) begin flush_m = 1; killed = 1; end
      step();
    end
    flush_m = 0;
    dm_ack = 1; dm_rdata = rdata;
    #1;
    check("ack_req", dm_req, 1);
    check("ack_stall", stall_m, 0);
    check("ack_be", dm_be, exp_be(st, sop, addr));
    step();
    idle_inputs();
    check("stall_cycles", stall_cnt, delay + 1);
    check("post_req", dm_req, 0);
    check("w_regwrite", RegWriteW, killed ? 1'b0 : rw);
    if (!killed) begin
      check("w_rdw", RDW, rdata);
      check("w_awrite", AwriteW, rd);
      check("w_aluout", ALUoutW, addr);
      check("w_pc4", PC_4W, pc);
      check("w_loadop", LoadopW, lop);
    end
  endtask

  task automatic nonmem(input logic [31:0] alu, input logic [4:0] rd, input bit rw);
    logic [31:0] pc;
    logic [1:0]  m2r;
    pc = $urandom;
    m2r = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'd2;
    valid_m = 1; flush_m = 0; RegWriteM = rw; MemtoRegM = m2r; StoreopM = 0;
    LoadopM = 3'($urandom_range(0, 4)); ALUoutM = alu; AwriteM = rd; PC_4M = pc;
    WriteDataM = $urandom;
    #1;
    check("nm_stall", stall_m, 0);
    check("nm_req", dm_req, 0);
    step();
    idle_inputs();
    check("nm_aluout", ALUoutW, alu);
    check("nm_awrite", AwriteW, rd);
    check("nm_regwrite", RegWriteW, rw);
    check("nm_memtoreg", MemtoRegW, m2r);
    check("nm_pc4", PC_4W, pc);
  endtask

  task automatic idle_flush();
    valid_m = 1; flush_m = 1; RegWriteM = 1; MemtoRegM = 1; LoadopM = 0;
    StoreopM = 0; ALUoutM = 32'h40; AwriteM = 5'd9;
    #1;
    check("fl_stall", stall_m, 0);
    step();
    idle_inputs();
    check("fl_bubble", RegWriteW, 0);
    check("fl_req", dm_req, 0);
  endtask

  initial begin
    int k, dly, fat;
    logic [31:0] a;
    #1 reset_n = 0;
    #2;
    check("rst_req", dm_req, 0);
    check("rst_stall", stall_m, 0);
    check("rst_regwrite", RegWriteW, 0);
    check("rst_buserr", bus_err, 0);
    check("rst_be", dm_be, 0);
    check("rst_rdw", RDW, 0);
    #9 reset_n = 1;
    step();

    mem_txn(0, 3'd0, 2'd0, 32'h10, 32'h0, 3, -1, 32'hDEADBEEF, 5'd5, 1);
    mem_txn(1, 3'd0, 2'd3, 32'h13, 32'h0000_00A5, 1, -1, 32'h0, 5'd0, 0);
    mem_txn(1, 3'd0, 2'd2, 32'h12, 32'h1234_5678, 0, -1, 32'h0, 5'd0, 0);
    mem_txn(0, 3'd0, 2'd0, 32'h102, 32'h0, 0, -1, 32'h0, 5'd3, 1);
    mem_txn(1, 3'd0, 2'd2, 32'h1, 32'h0, 0, -1, 32'h0, 5'd0, 0);
    nonmem(32'h7, 5'd8, 1);
    mem_txn(0, 3'd1, 2'd0, 32'h21, 32'h0, 2, 0, 32'h5555_AAAA, 5'd4, 1);
    idle_flush();

    for (int n = 0; n < 60; n++) begin
      k = $urandom_range(0, 9);
      a = $urandom;
      dly = $urandom_range(0, 3);
      fat = -1;
      if (dly > 0 && $urandom_range(0, 3) == 0) fat = $urandom_range(0, dly - 1);
      if (k <= 2) nonmem(a, 5'($urandom), 1'($urandom));
      else if (k <= 5) mem_txn(0, 3'($urandom_range(0, 4)), 2'd0, a, 32'h0, dly, fat,
                               $urandom, 5'($urandom), 1);
      else if (k <= 8) mem_txn(1, 3'd0, 2'($urandom_range(1, 3)), a, $urandom, dly, fat,
                               32'h0, 5'd0, 0);
      else idle_flush();
    end

    // Timeout: no ack for ACK_TIMEOUT busy cycles.
    valid_m = 1; RegWriteM = 1; MemtoRegM = 1; LoadopM = 0; StoreopM = 0;
    ALUoutM = 32'h80; AwriteM = 5'd6;
    step();
    for (int i = 0; i < 4; i++) begin
      check("to_req", dm_req, 1);
      check("to_buserr_early", bus_err, 0);
      if (i == 3) idle_inputs();
      step();
    end
    check("to_buserr", bus_err, 1);
    check("to_req_drop", dm_req, 0);
    check("to_stall", stall_m, 0);
    check("to_bubble", RegWriteW, 0);
    step();
    check("to_pulse_end", bus_err, 0);

    // Asynchronous reset while a store is outstanding.
    valid_m = 1; StoreopM = 2'd1; ALUoutM = 32'h200; WriteDataM = 32'hCAFE_F00D;
    step();
    check("rb_req", dm_req, 1);
    idle_inputs();
    #2 reset_n = 0;
    #1;
    check("rb_req_async", dm_req, 0);
    check("rb_regwrite", RegWriteW, 0);
    #2 reset_n = 1;
    step();
    check("rb_req_after", dm_req, 0);
    mem_txn(0, 3'd4, 2'd0, 32'h302, 32'h0, 1, -1, 32'h0BAD_F00D, 5'd7, 1);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
